ccff_bitstream_loader: RTL and testbench

Configuration-chain feeder that sits directly upstream of the switch/connection-block ccff chain. It accepts configuration words from the host over a valid/ready interface and serialises them MSB-first onto ccff_head. It generates the shift enable for the gated prog_clk and counts exactly CHAIN_LEN shifts. At the end it performs a one-bit sanity check on the chain's ccff_tail.

---
 rtl/ccff_loader_pkg.sv | 18 +
 rtl/ccff_word_serializer.sv | 28 ++
 rtl/ccff_bitstream_loader.sv | 121 ++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the ccff bitstream loader.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Number of host words needed to cover the whole chain (ceiling division).
    function automatic int unsigned words_per_load(input int unsigned chain_len,
                                                   input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Parallel-in / serial-out word register; msb is the bit currently presented.
module ccff_word_serializer #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              msb
);

    logic [WORD_W-1:0] sreg;

    // Load has priority; shift moves the next bit into the msb position.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {sreg[WORD_W-2:0], 1'b0};
        end
    end

    assign msb = sreg[WORD_W-1];

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Feeds host configuration words MSB-first into the ccff chain and checks the tail.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic             prog_clk,
    input  logic             pReset,
    input  logic             start,
    input  logic             word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic             word_ready,
    output logic             ccff_head,
    output logic             chain_clk_en,
    input  logic             ccff_tail,
    output logic             busy,
    output logic             done,
    output logic             check_ok,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] bit_idx;
    logic             first_bit;
    logic             load_word;
    logic             shift_word;
    logic             last_chain_bit;
    logic             last_word_bit;
    logic             start_ok;

    assign last_chain_bit = (bit_count == CNT_W'(CHAIN_LEN - 1));
    assign last_word_bit  = (bit_idx == IDX_W'(WORD_W - 1));
    assign start_ok       = start && ((state == ST_IDLE) || (state == ST_DONE));

    // State register.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) next_state = ST_FETCH;
            ST_FETCH:         if (word_valid) next_state = ST_SHIFT;
            ST_SHIFT: begin
                if (last_chain_bit)     next_state = ST_CHECK;
                else if (last_word_bit) next_state = ST_FETCH;
            end
            ST_CHECK:         next_state = ST_DONE;
            default:          next_state = ST_IDLE;
        endcase
    end

    // Decode: the serializer only shifts when another bit of the same word follows,
    // so its msb (ccff_head) keeps the last presented bit while the chain is held.
    always_comb begin
        word_ready = (state == ST_FETCH);
        load_word  = (state == ST_FETCH) && word_valid;
        shift_word = (state == ST_SHIFT) && (next_state == ST_SHIFT);
    end

    // Registered status, counters and tail check.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            chain_clk_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            check_ok     <= 1'b0;
            bit_count    <= '0;
            bit_idx      <= '0;
            first_bit    <= 1'b0;
        end else begin
            chain_clk_en <= (next_state == ST_SHIFT);
            busy         <= (next_state == ST_FETCH) || (next_state == ST_SHIFT) ||
                            (next_state == ST_CHECK);
            if (start_ok) begin
                bit_count <= '0;
                done      <= 1'b0;
                check_ok  <= 1'b0;
            end
            if (state == ST_FETCH) begin
                bit_idx <= '0;
            end
            if (state == ST_SHIFT) begin
                if (bit_count != CNT_W'(CHAIN_LEN)) begin
                    bit_count <= bit_count + CNT_W'(1);
                end
                bit_idx <= last_word_bit ? '0 : bit_idx + IDX_W'(1);
                if (bit_count == '0) begin
                    first_bit <= ccff_head;
                end
            end
            if (state == ST_CHECK) begin
                check_ok <= (ccff_tail == first_bit);
                done     <= 1'b1;
            end
        end
    end

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .load     (load_word),
        .shift    (shift_word),
        .din      (word_data),
        .msb      (ccff_head)
    );

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 16/40 instance for the table and corner cases,
// a default 32/64 instance for back-to-back throughput.
module tb_ccff_bitstream_loader;
    import ccff_loader_pkg::*;

    localparam int unsigned AW  = 16;
    localparam int unsigned AL  = 40;
    localparam int unsigned ACW = $clog2(AL + 1);
    localparam int unsigned BW  = 32;
    localparam int unsigned BL  = 64;
    localparam int unsigned BCW = $clog2(BL + 1);

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic           a_start = 1'b0, a_valid = 1'b0;
    logic [AW-1:0]  a_data = '0;
    logic           a_ready, a_head, a_en, a_tail, a_busy, a_done, a_ok;
    logic [ACW-1:0] a_bc;
    logic           force_tail = 1'b0, tail_val = 1'b0;
    logic [AL-1:0]  chain_a;

    // Instance B signals
    logic           b_start = 1'b0, b_valid = 1'b0;
    logic [BW-1:0]  b_data = '0;
    logic           b_ready, b_head, b_en, b_tail, b_busy, b_done, b_ok;
    logic [BCW-1:0] b_bc;
    logic [BL-1:0]  chain_b;

    ccff_bitstream_loader #(.WORD_W(AW), .CHAIN_LEN(AL)) dut_a (
        .prog_clk(clk), .pReset(rst), .start(a_start), .word_valid(a_valid),
        .word_data(a_data), .word_ready(a_ready), .ccff_head(a_head),
        .chain_clk_en(a_en), .ccff_tail(a_tail), .busy(a_busy), .done(a_done),
        .check_ok(a_ok), .bit_count(a_bc)
    );

    ccff_bitstream_loader dut_b (
        .prog_clk(clk), .pReset(rst), .start(b_start), .word_valid(b_valid),
        .word_data(b_data), .word_ready(b_ready), .ccff_head(b_head),
        .chain_clk_en(b_en), .ccff_tail(b_tail), .busy(b_busy), .done(b_done),
        .check_ok(b_ok), .bit_count(b_bc)
    );

    // Gated-clock chain models: capture head on edges that end an enabled cycle.
    always @(posedge clk) if (a_en) chain_a <= {chain_a[AL-2:0], a_head};
    always @(posedge clk) if (b_en) chain_b <= {chain_b[BL-2:0], b_head};
    assign a_tail = force_tail ? tail_val : chain_a[AL-1];
    assign b_tail = chain_b[BL-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] w0, w1, w2;
        int          stall;
        logic        start_mid;
        logic        force_t;
        logic        tval;
        logic        exp_ok;
    } vec_t;

    vec_t vecs[12];

    // One full load on instance A, checking each presented bit against the word stream.
    task automatic run_a(input vec_t v);
        logic [AW-1:0] words[3];
        logic [47:0]   stream;
        logic [AL-1:0] snap;
        logic          prev_head;
        int            sent, nbits, stall_left;
        bit            fin;
        words      = '{v.w0, v.w1, v.w2};
        stream     = {v.w0, v.w1, v.w2};
        snap       = '0;
        sent       = 0;
        nbits      = 0;
        fin        = 1'b0;
        stall_left = v.stall;
        force_tail = v.force_t;
        tail_val   = v.tval;
        @(negedge clk);
        prev_head = a_head;
        a_start   = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("a_done_clr", a_done, 1'b0);
        chk("a_busy_on", a_busy, 1'b1);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (a_done) begin
                fin = 1'b1;
            end else begin
                a_start = v.start_mid && a_en && (nbits == 5);
                if (a_en) begin
                    if (nbits < int'(AL)) chk("a_head_bit", a_head, stream[47-nbits]);
                    else chk("a_en_extra", 64'(nbits), 64'(AL - 1));
                    chk("a_bit_count", a_bc, 64'(nbits));
                    nbits++;
                end else begin
                    chk("a_head_hold", a_head, prev_head);
                end
                prev_head = a_head;
                if (a_ready && sent < 3) begin
                    if (sent == 1 && stall_left > 0) begin
                        if (stall_left == v.stall) snap = chain_a;
                        a_valid = 1'b0;
                        stall_left--;
                        chk("a_stall_en", a_en, 1'b0);
                    end else begin
                        if (sent == 1 && v.stall > 0) chk("a_stall_chain", chain_a, snap);
                        a_valid = 1'b1;
                        a_data  = words[sent];
                        sent++;
                    end
                end else begin
                    a_valid = 1'b0;
                end
            end
        end
        a_valid = 1'b0;
        a_start = 1'b0;
        chk("a_timeout", fin, 1'b1);
        chk("a_words", 64'(sent), 64'(words_per_load(AL, AW)));
        chk("a_en_cycles", 64'(nbits), 64'(AL));
        chk("a_bc_final", a_bc, 64'(AL));
        chk("a_busy_off", a_busy, 1'b0);
        chk("a_ready_done", a_ready, 1'b0);
        chk("a_check_ok", a_ok, v.exp_ok);
        chk("a_chain", chain_a, {v.w0, v.w1, v.w2[15:8]});
        @(negedge clk);
        chk("a_done_held", a_done, 1'b1);
        chk("a_ok_held", a_ok, v.exp_ok);
        force_tail = 1'b0;
    endtask

    // Back-to-back load on instance B with valid held high the whole time.
    task automatic run_b(input logic [BW-1:0] w0, input logic [BW-1:0] w1);
        logic [63:0] stream;
        int          sent, nbits, work;
        bit          fin;
        stream = {w0, w1};
        sent   = 0;
        nbits  = 0;
        work   = 0;
        fin    = 1'b0;
        @(negedge clk);
        b_start = 1'b1;
        b_valid = 1'b1;
        b_data  = w0;
        @(negedge clk);
        b_start = 1'b0;
        chk("b_done_clr", b_done, 1'b0);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (b_done) begin
                fin = 1'b1;
            end else begin
                if (b_busy && (b_ready || b_en)) work++;
                if (b_en) begin
                    if (nbits < int'(BL)) chk("b_head_bit", b_head, stream[63-nbits]);
                    else chk("b_en_extra", 64'(nbits), 64'(BL - 1));
                    nbits++;
                end
                if (b_ready) begin
                    b_data = (sent == 0) ? w0 : w1;
                    sent++;
                end
            end
        end
        b_valid = 1'b0;
        chk("b_timeout", fin, 1'b1);
        chk("b_words", 64'(sent), 64'(words_per_load(BL, BW)));
        chk("b_fetch_shift_cycles", 64'(work), 64'd66);
        chk("b_en_cycles", 64'(nbits), 64'(BL));
        chk("b_bc_final", b_bc, 64'(BL));
        chk("b_check_ok", b_ok, 1'b1);
        chk("b_chain", chain_b, {w0, w1});
    endtask

    initial begin
        // Directed table entries, then randomized ones with model-derived check_ok.
        vecs[0] = '{16'hA5F0, 16'h3C3C, 16'hFF5A, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{16'hA5F0, 16'h3C3C, 16'hFF5A, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'hA5F0, 16'h3C3C, 16'hFF5A, 7, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h1234, 16'hABCD, 16'hEF01, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'h5A5A, 16'h0F0F, 16'hC3C3, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h5A5A, 16'h0F0F, 16'hC3C3, 0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 6; i < 12; i++) begin
            vecs[i].w0        = 16'($urandom);
            vecs[i].w1        = 16'($urandom);
            vecs[i].w2        = 16'($urandom);
            vecs[i].stall     = int'($urandom_range(0, 3));
            vecs[i].start_mid = 1'($urandom_range(0, 1));
            vecs[i].force_t   = 1'($urandom_range(0, 1));
            vecs[i].tval      = 1'($urandom_range(0, 1));
            vecs[i].exp_ok    = vecs[i].force_t ? (vecs[i].tval == vecs[i].w0[15]) : 1'b1;
        end

        // Power-on reset.
        #3 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_a_outs", {a_ready, a_head, a_en, a_busy, a_done, a_ok}, 6'b0);
        chk("rst_a_bc", a_bc, 0);
        chk("rst_b_outs", {b_ready, b_head, b_en, b_busy, b_done, b_ok}, 6'b0);
        chk("rst_b_bc", b_bc, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ready", a_ready, 1'b0);

        // Reset asserted in the middle of SHIFT.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_valid = 1'b1;
        a_data  = 16'hA5F0;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_shift_en", a_en, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_outs", {a_ready, a_head, a_en, a_busy, a_done, a_ok}, 6'b0);
        chk("mid_rst_bc", a_bc, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {a_ready, a_busy, a_done, a_en}, 4'b0);
        end

        for (int i = 0; i < 12; i++) run_a(vecs[i]);

        run_b(32'hDEADBEEF, 32'h0123ABCD);
        run_b(32'($urandom), 32'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
